// File: rtl/jesd_pkg.sv
// Shared constants and types for the JESD204B TX ILA sequencer.
// Control codes are applied by the downstream inserter.
package jesd_pkg;

    localparam logic [7:0] K_R = 8'h1C;
    localparam logic [7:0] K_Q = 8'h9C;
    localparam logic [7:0] K_A = 8'h7C;
    localparam int MF_LEN = 32;

    typedef enum logic [1:0] {
        IDLE,
        ILA,
        DATA
    } state_t;

    function automatic logic [4:0] oh_idx(input logic [31:0] v);
        logic [4:0] r;
        r = '0;
        for (int i = 0; i < 32; i++)
            if (v[i]) r = r | 5'(i);
        return r;
    endfunction

endpackage

// File: rtl/jesd_ila_seq_if.sv
// Payload valid/ready handshake into the ILA sequencer.
// The source drives data and valid; the sequencer returns ready.
interface jesd_ila_seq_if;

    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );

endinterface

// File: rtl/jesd_onehot_ring.sv
// Parameterised one-hot rotator with clear, load-to-bit-0 and advance.
// q_nxt exposes the value the register takes at the next edge.
module jesd_onehot_ring #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         load,
    input  logic         adv,
    output logic [W-1:0] q,
    output logic [W-1:0] q_nxt,
    output logic         wrap
);

    always_comb begin
        q_nxt = q;
        if (clr)
            q_nxt = '0;
        else if (load)
            q_nxt = W'(1);
        else if (adv)
            q_nxt = {q[W-2:0], q[W-1]};
    end

    assign wrap = adv & q[W-1] & ~clr & ~load;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            q <= '0;
        else
            q <= q_nxt;
    end

endmodule

// File: rtl/jesd_ila_seq.sv
// JESD204B TX ILA sequencer: octet/multiframe position rings and the
// pre-substitution octet stream (ILA filler, link config, then payload).
module jesd_ila_seq
    import jesd_pkg::*;
#(
    parameter int ILA_MF    = 4,
    parameter int CFG_BYTES = 14,
    parameter int CFG_START = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cgs_done,
    input  logic                   sync_req,
    input  logic [8*CFG_BYTES-1:0] cfg_bytes,
    jesd_ila_seq_if.slave          tx_if,
    output logic [7:0]             data_out,
    output logic [MF_LEN-1:0]      byte_cnt,
    output logic [ILA_MF-1:0]      ila_cnt,
    output logic                   ila_active
);

    state_t state_q, state_d;
    logic [8*CFG_BYTES-1:0] shadow;
    logic [MF_LEN-1:0] byte_nxt;
    logic [ILA_MF-1:0] ila_nxt;
    logic byte_wrap, ila_wrap_unused;
    logic rclr, rload, radv;
    logic [7:0] data_d;
    logic [4:0] p5, m5;
    int k;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (!sync_req && cgs_done) state_d = ILA;
            ILA: begin
                if (sync_req)
                    state_d = IDLE;
                else if (byte_cnt[MF_LEN-1] && ila_cnt[ILA_MF-1])
                    state_d = DATA;
            end
            DATA: if (sync_req) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign rclr  = (state_d != ILA);
    assign rload = (state_q != ILA) && (state_d == ILA);
    assign radv  = (state_q == ILA) && (state_d == ILA);

    jesd_onehot_ring #(.W(MF_LEN)) u_byte (
        .clk(clk), .rst_n(rst_n),
        .clr(rclr), .load(rload), .adv(radv),
        .q(byte_cnt), .q_nxt(byte_nxt), .wrap(byte_wrap)
    );

    jesd_onehot_ring #(.W(ILA_MF)) u_mf (
        .clk(clk), .rst_n(rst_n),
        .clr(rclr), .load(rload), .adv(byte_wrap),
        .q(ila_cnt), .q_nxt(ila_nxt), .wrap(ila_wrap_unused)
    );

    // Octet is chosen from the position the rings move to on this edge
    always_comb begin
        data_d = 8'h00;
        p5 = oh_idx(32'(byte_nxt));
        m5 = oh_idx(32'(ila_nxt));
        k = int'(p5) - CFG_START;
        if (state_d == ILA) begin
            if (m5 == 5'd1 && k >= 0 && k < CFG_BYTES)
                data_d = shadow[k*8 +: 8];
            else
                data_d = {1'b0, m5[1:0], p5};
        end else if (state_d == DATA && state_q == DATA) begin
            data_d = tx_if.tx_valid ? tx_if.tx_data : 8'h00;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            shadow         <= '0;
            data_out       <= 8'h00;
            ila_active     <= 1'b0;
            tx_if.tx_ready <= 1'b0;
        end else begin
            state_q        <= state_d;
            if (rload) shadow <= cfg_bytes;
            data_out       <= data_d;
            ila_active     <= (state_d == ILA);
            tx_if.tx_ready <= (state_d == DATA);
        end
    end

endmodule

// File: tb/tb_jesd_ila_seq.sv
// Directed self-checking bench for jesd_ila_seq.
// Expected values are hand-derived octet/multiframe positions.
module tb_jesd_ila_seq;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         cgs_done = 1'b0;
    logic         sync_req = 1'b0;
    logic [111:0] cfg_bytes = '0;
    logic [7:0]   data_out;
    logic [31:0]  byte_cnt;
    logic [3:0]   ila_cnt;
    logic         ila_active;
    int n_cmp = 0;
    int n_bad = 0;

    jesd_ila_seq_if tx_if ();

    jesd_ila_seq dut (
        .clk(clk), .rst_n(rst_n),
        .cgs_done(cgs_done), .sync_req(sync_req),
        .cfg_bytes(cfg_bytes), .tx_if(tx_if.slave),
        .data_out(data_out), .byte_cnt(byte_cnt),
        .ila_cnt(ila_cnt), .ila_active(ila_active)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".data"}, 32'(data_out), 32'h0);
        chk({tag, ".byte"}, byte_cnt, 32'h0);
        chk({tag, ".ila"}, 32'(ila_cnt), 32'h0);
        chk({tag, ".act"}, 32'(ila_active), 32'h0);
        chk({tag, ".rdy"}, 32'(tx_if.tx_ready), 32'h0);
    endtask

    // Caller has set cgs_done so that the next edge is ILA edge 0
    task automatic run_ila(input string tag, input bit cfg_chk,
                           input int stop_at);
        for (int n = 0; n < 128; n++) begin
            tick();
            chk({tag, ".byte"}, byte_cnt, 32'h1 << (n % 32));
            chk({tag, ".ila"}, 32'(ila_cnt), 32'h1 << (n / 32));
            chk({tag, ".act"}, 32'(ila_active), 32'h1);
            if (cfg_chk) begin
                if (n >= 34 && n <= 47)
                    chk({tag, ".cfg"}, 32'(data_out), 32'(8'hA0 + n - 34));
                if (n == 0)   chk({tag, ".f0"}, 32'(data_out), 32'h00);
                if (n == 33)  chk({tag, ".f33"}, 32'(data_out), 32'h21);
                if (n == 48)  chk({tag, ".f48"}, 32'(data_out), 32'h30);
                if (n == 65)  chk({tag, ".f65"}, 32'(data_out), 32'h41);
                if (n == 100) chk({tag, ".f100"}, 32'(data_out), 32'h64);
                if (n == 40)  cfg_bytes = {14{8'h55}};
            end
            if (n == stop_at) return;
        end
        tick();
        chk({tag, ".e128act"}, 32'(ila_active), 32'h0);
        chk({tag, ".e128rdy"}, 32'(tx_if.tx_ready), 32'h1);
        chk({tag, ".e128byte"}, byte_cnt, 32'h0);
        chk({tag, ".e128ila"}, 32'(ila_cnt), 32'h0);
    endtask

    logic [7:0] prev_d;
    logic       prev_v;

    initial begin
        tx_if.tx_data  = 8'h00;
        tx_if.tx_valid = 1'b0;
        #12;
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        chk_zero("idle");

        for (int k = 0; k < 14; k++) cfg_bytes[k*8 +: 8] = 8'hA0 + 8'(k);
        cgs_done = 1'b1;
        run_ila("ila1", 1'b1, -1);

        // Payload: ramp with alternating valid, one-cycle latency
        prev_d = 8'h00;
        prev_v = 1'b0;
        for (int i = 0; i < 16; i++) begin
            tx_if.tx_data  = 8'(i * 17);
            tx_if.tx_valid = ~i[0];
            prev_d = tx_if.tx_data;
            prev_v = tx_if.tx_valid;
            tick();
            chk("data.out", 32'(data_out), prev_v ? 32'(prev_d) : 32'h0);
            chk("data.byte", byte_cnt, 32'h0);
        end
        tx_if.tx_valid = 1'b0;

        sync_req = 1'b1;
        tick();
        chk_zero("sync_data");
        sync_req = 1'b0;
        run_ila("ila2", 1'b0, 50);
        sync_req = 1'b1;
        tick();
        chk_zero("sync_ila");
        sync_req = 1'b0;
        run_ila("ila3", 1'b0, -1);

        sync_req = 1'b1;
        tick();
        sync_req = 1'b0;
        run_ila("ila4", 1'b0, 70);
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero("arst");
        @(negedge clk);
        rst_n = 1'b1;
        run_ila("ila5", 1'b0, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
